piradip_axis_fifo_pkt: RTL and testbench

PIRADIP_AXIS_FIFO_PKT -- requirements
Module: piradip_axis_fifo_pkt

---
 rtl/piradip_axis_fifo_pkt.sv | 126 ++++++++++++
 tb/tb_piradip_axis_fifo_pkt.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/piradip_axis_fifo_pkt.sv
// AXI-Stream FIFO with word and packet occupancy, level flags and optional
// store-and-forward packet mode; oversize packets fall back to cut-through.
module piradip_axis_fifo_pkt #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 32,
  parameter int PACKET_MODE   = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  flush,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         pkt_count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of 8 and at least 8");
  end
  if (DEPTH < 4 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 4..4096");
  end
  if (PACKET_MODE != 0 && PACKET_MODE != 1) begin : g_bad_packet_mode
    $error("PACKET_MODE must be 0 or 1");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       pkt_count_q, pkt_count_d;
  logic                cut_through_q, cut_through_d;
  logic                wr_en, rd_en, pkt_ok;

  // Ready/valid come from registered state plus the two clear inputs only,
  // so a read in the same cycle never opens a slot in a full FIFO.
  assign s_axis_tready = (count_q < DEPTH_C) & ~areset & ~flush;
  assign wr_en         = s_axis_tvalid & s_axis_tready;

  assign pkt_ok        = (PACKET_MODE == 0) | (pkt_count_q != '0) | cut_through_q;
  assign m_axis_tvalid = (count_q != '0) & pkt_ok & ~areset & ~flush;
  assign rd_en         = m_axis_tvalid & m_axis_tready;

  assign {m_axis_tlast, m_axis_tdata} = mem_q[rd_ptr_q];

  assign count        = count_q;
  assign pkt_count    = pkt_count_q;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    pkt_count_d   = pkt_count_q;
    cut_through_d = cut_through_q;
    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      pkt_count_d   = '0;
      cut_through_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      case ({wr_en & s_axis_tlast, rd_en & m_axis_tlast})
        2'b10:   pkt_count_d = pkt_count_q + CW'(1);
        2'b01:   pkt_count_d = pkt_count_q - CW'(1);
        default: pkt_count_d = pkt_count_q;
      endcase
      // A full FIFO with no complete packet can never release one: stream it.
      if (rd_en && m_axis_tlast)
        cut_through_d = 1'b0;
      else if (count_q == DEPTH_C && pkt_count_q == '0)
        cut_through_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pkt_count_q   <= '0;
      cut_through_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pkt_count_q   <= pkt_count_d;
      cut_through_q <= cut_through_d;
    end
  end

endmodule

// File: tb/tb_piradip_axis_fifo_pkt.sv
// Scoreboard bench: one FIFO in streaming mode, one in packet mode.
module tb_piradip_axis_fifo_pkt;

  logic clk = 1'b0;
  logic rst, flush;

  logic        s0_tvalid, s0_tlast, s0_tready, m0_tvalid, m0_tlast, m0_tready;
  logic [31:0] s0_tdata, m0_tdata;
  logic [5:0]  cnt0, pkt0;
  logic        af0, ae0;

  logic        s1_tvalid, s1_tlast, s1_tready, m1_tvalid, m1_tlast, m1_tready;
  logic [31:0] s1_tdata, m1_tdata;
  logic [5:0]  cnt1, pkt1;
  logic        af1, ae1;

  int checks = 0;
  int failures = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  always #5 clk = ~clk;

  piradip_axis_fifo_pkt #(.DATA_WIDTH(32), .DEPTH(32), .PACKET_MODE(0)) u_dut0 (
    .aclk(clk), .areset(rst), .flush(flush),
    .s_axis_tvalid(s0_tvalid), .s_axis_tdata(s0_tdata), .s_axis_tlast(s0_tlast),
    .s_axis_tready(s0_tready),
    .m_axis_tvalid(m0_tvalid), .m_axis_tdata(m0_tdata), .m_axis_tlast(m0_tlast),
    .m_axis_tready(m0_tready),
    .count(cnt0), .pkt_count(pkt0), .almost_full(af0), .almost_empty(ae0)
  );

  piradip_axis_fifo_pkt #(.DATA_WIDTH(32), .DEPTH(32), .PACKET_MODE(1)) u_dut1 (
    .aclk(clk), .areset(rst), .flush(flush),
    .s_axis_tvalid(s1_tvalid), .s_axis_tdata(s1_tdata), .s_axis_tlast(s1_tlast),
    .s_axis_tready(s1_tready),
    .m_axis_tvalid(m1_tvalid), .m_axis_tdata(m1_tdata), .m_axis_tlast(m1_tlast),
    .m_axis_tready(m1_tready),
    .count(cnt1), .pkt_count(pkt1), .almost_full(af1), .almost_empty(ae1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, wait (bounded) for acceptance, then record it as expected output.
  task automatic wr(input int sel, input logic [31:0] d, input logic l);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    if (sel == 0) begin s0_tvalid = 1'b1; s0_tdata = d; s0_tlast = l; end
    else          begin s1_tvalid = 1'b1; s1_tdata = d; s1_tlast = l; end
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = (sel == 0) ? s0_tready : s1_tready;
      step();
      n++;
    end
    if (sel == 0) s0_tvalid = 1'b0; else s1_tvalid = 1'b0;
    chk("wr_accept", {63'd0, ok}, 64'd1);
    if (ok) begin
      if (sel == 0) q0.push_back({l, d}); else q1.push_back({l, d});
    end
  endtask

  always @(negedge clk) begin
    if (m0_tvalid && m0_tready) begin
      if (q0.size() == 0) chk("rd0_unexpected", {31'd0, m0_tlast, m0_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("rd0_beat", {31'd0, m0_tlast, m0_tdata}, {31'd0, q0.pop_front()});
    end
    if (m1_tvalid && m1_tready) begin
      if (q1.size() == 0) chk("rd1_unexpected", {31'd0, m1_tlast, m1_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("rd1_beat", {31'd0, m1_tlast, m1_tdata}, {31'd0, q1.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0;
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0; m0_tready = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0; m1_tready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_s_tready", {63'd0, s0_tready}, 64'd0);
    chk("rst_m_tvalid", {63'd0, m0_tvalid}, 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_count", {58'd0, cnt0}, 64'd0);
    chk("post_rst_pkt", {58'd0, pkt0}, 64'd0);
    chk("post_rst_tvalid", {63'd0, m0_tvalid}, 64'd0);
    chk("post_rst_afull", {63'd0, af0}, 64'd0);
    chk("post_rst_aempty", {63'd0, ae0}, 64'd1);
    chk("post_rst_s_tready", {63'd0, s0_tready}, 64'd1);
    chk("post_rst_aempty1", {63'd0, ae1}, 64'd1);
    chk("post_rst_afull1", {63'd0, af1}, 64'd0);
    step();

    // single beat, visible the cycle after the write
    wr(0, 32'hA5A5_0001, 1'b1);
    chk("one_tvalid", {63'd0, m0_tvalid}, 64'd1);
    chk("one_tdata", {32'd0, m0_tdata}, 64'hA5A5_0001);
    chk("one_tlast", {63'd0, m0_tlast}, 64'd1);
    chk("one_count", {58'd0, cnt0}, 64'd1);
    chk("one_pkt", {58'd0, pkt0}, 64'd1);
    m0_tready = 1'b1; step(); m0_tready = 1'b0;
    chk("one_drained", {58'd0, cnt0}, 64'd0);

    // fill to DEPTH, tlast every 8th beat
    for (int i = 0; i < 32; i++) begin
      wr(0, 32'h100 + i, (i % 8) == 7);
      chk("fill_count", {58'd0, cnt0}, 64'(i + 1));
      chk("fill_afull", {63'd0, af0}, {63'd0, (i + 1) >= 30});
      chk("fill_aempty", {63'd0, ae0}, {63'd0, (i + 1) <= 2});
    end
    chk("full_pkt", {58'd0, pkt0}, 64'd4);
    s0_tvalid = 1'b1; s0_tdata = 32'hDEAD; s0_tlast = 1'b0;
    @(negedge clk);
    chk("full_s_tready", {63'd0, s0_tready}, 64'd0);
    step();
    s0_tvalid = 1'b0;
    chk("full_no_write", {58'd0, cnt0}, 64'd32);
    m0_tready = 1'b1; step(); m0_tready = 1'b0;
    chk("one_read_count", {58'd0, cnt0}, 64'd31);
    chk("one_read_s_tready", {63'd0, s0_tready}, 64'd1);
    chk("one_read_afull", {63'd0, af0}, 64'd1);
    m0_tready = 1'b1; repeat (26) step(); m0_tready = 1'b0;
    chk("five_count", {58'd0, cnt0}, 64'd5);
    chk("five_pkt", {58'd0, pkt0}, 64'd1);
    chk("five_aempty", {63'd0, ae0}, 64'd0);

    // simultaneous write and read
    m0_tready = 1'b1;
    for (int i = 0; i < 10; i++) wr(0, 32'h200 + i, i == 9);
    m0_tready = 1'b0;
    chk("wrrd_count", {58'd0, cnt0}, 64'd5);
    chk("wrrd_pkt", {58'd0, pkt0}, 64'd1);

    // flush with a write and a read offered in the flush cycle
    for (int i = 0; i < 5; i++) wr(0, 32'h300 + i, 1'b0);
    chk("pre_flush_count", {58'd0, cnt0}, 64'd10);
    flush = 1'b1; s0_tvalid = 1'b1; s0_tdata = 32'hBAD; s0_tlast = 1'b1; m0_tready = 1'b1;
    @(negedge clk);
    chk("flush_s_tready", {63'd0, s0_tready}, 64'd0);
    chk("flush_m_tvalid", {63'd0, m0_tvalid}, 64'd0);
    step();
    flush = 1'b0; s0_tvalid = 1'b0; m0_tready = 1'b0;
    q0.delete();
    chk("flush_count", {58'd0, cnt0}, 64'd0);
    chk("flush_pkt", {58'd0, pkt0}, 64'd0);
    chk("flush_tvalid", {63'd0, m0_tvalid}, 64'd0);
    chk("flush_aempty", {63'd0, ae0}, 64'd1);
    wr(0, 32'h400, 1'b1);
    chk("post_flush_count", {58'd0, cnt0}, 64'd1);
    chk("post_flush_tvalid", {63'd0, m0_tvalid}, 64'd1);
    m0_tready = 1'b1; step(); m0_tready = 1'b0;

    // packet mode: held until tlast stored
    m1_tready = 1'b1;
    wr(1, 32'h10, 1'b0);
    chk("pkt_hold1", {63'd0, m1_tvalid}, 64'd0);
    wr(1, 32'h11, 1'b0);
    chk("pkt_hold2", {63'd0, m1_tvalid}, 64'd0);
    wr(1, 32'h12, 1'b1);
    chk("pkt_release", {63'd0, m1_tvalid}, 64'd1);
    repeat (3) step();
    chk("pkt_drained", {58'd0, cnt1}, 64'd0);

    // oversize packet: cut-through once full
    for (int i = 0; i < 40; i++) begin
      wr(1, 32'h500 + i, i == 39);
      if (i == 31) begin
        chk("big_full_count", {58'd0, cnt1}, 64'd32);
        chk("big_full_tvalid", {63'd0, m1_tvalid}, 64'd0);
      end
    end
    n = 0;
    while (q1.size() != 0 && n < 200) begin step(); n++; end
    chk("big_undelivered", 64'(q1.size()), 64'd0);
    chk("big_count", {58'd0, cnt1}, 64'd0);
    chk("big_pkt", {58'd0, pkt1}, 64'd0);

    // cut-through must be cleared: next packet is held again
    wr(1, 32'h600, 1'b0);
    chk("after_cut_hold", {63'd0, m1_tvalid}, 64'd0);
    wr(1, 32'h601, 1'b1);
    chk("after_cut_release", {63'd0, m1_tvalid}, 64'd1);
    repeat (2) step();
    m1_tready = 1'b0;
    chk("after_cut_count", {58'd0, cnt1}, 64'd0);

    repeat (2) step();
    chk("q0_left", 64'(q0.size()), 64'd0);
    chk("q1_left", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
